// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for a single 2-input gate: walks {a,b} through 00..11,
// samples gate_y at the end of each settle window and checks it against EXP_TT.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, gate inputs parked at 0, results held
// RUN    | driving vector idx, counting the settle window
// FIN    | one-cycle done pulse, pass resolved, then back to IDLE
module gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [3:0]  EXP_TT     = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       gate_y,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYC - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gate_a_d, gate_b_d, busy_d, done_d, pass_d;
    logic [2:0] err_cnt_d;
    logic [3:0] fail_vec_d;
    logic       mismatch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 8'd0;
            gate_a   <= 1'b0;
            gate_b   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 3'd0;
            fail_vec <= 4'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            gate_a   <= gate_a_d;
            gate_b   <= gate_b_d;
            busy     <= busy_d;
            done     <= done_d;
            pass     <= pass_d;
            err_cnt  <= err_cnt_d;
            fail_vec <= fail_vec_d;
        end
    end

    // Every output is computed here one cycle early so the ports come straight from flops.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        gate_a_d   = 1'b0;
        gate_b_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        pass_d     = pass;
        err_cnt_d  = err_cnt;
        fail_vec_d = fail_vec;
        // Case inequality so an X/Z gate output is a failure, never a silent pass.
        mismatch   = (gate_y !== EXP_TT[idx_q]);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    idx_d      = 2'd0;
                    cnt_d      = 8'd0;
                    err_cnt_d  = 3'd0;
                    fail_vec_d = 4'd0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                busy_d               = 1'b1;
                {gate_a_d, gate_b_d} = idx_q;
                cnt_d                = cnt_q + 8'd1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d = 8'd0;
                    if (mismatch) begin
                        err_cnt_d         = err_cnt + 3'd1;
                        fail_vec_d[idx_q] = 1'b1;
                    end
                    if (idx_q == 2'd3) begin
                        state_d              = S_FIN;
                        busy_d               = 1'b0;
                        done_d               = 1'b1;
                        {gate_a_d, gate_b_d} = 2'b00;
                        pass_d               = (err_cnt_d == 3'd0);
                    end else begin
                        idx_d                = idx_q + 2'd1;
                        {gate_a_d, gate_b_d} = idx_q + 2'd1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
- Built-in self-test sequencer for one 2-input switch-level gate (AND, OR, NAND, ...).
- On `start`, drives the gate's `a`/`b` inputs through all four combinations in order 00, 01, 10, 11, and holds each vector for a settle window.
- Samples the gate output at the end of each window, compares it against a parameterised truth table, and reports pass/fail, error count and a per-vector failure bitmap.
- Replaces the free-running `#10` stimulus used in gate benches with a clocked, reusable controller shared by all gate-level blocks.

Parameters:
- SETTLE_CYC, 2, clock cycles each vector is held before `gate_y` is sampled. Legal range 1..255.
- EXP_TT, 4'b1000, expected output per vector; bit index = {a,b}. Default is the AND truth table; OR = 4'b1110, NAND = 4'b0111.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request a test run; accepted only in IDLE.
- gate_y  input  1  output of the gate under test.
- gate_a  output  1  drive to gate input a.
- gate_b  output  1  drive to gate input b.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 when the last completed run had zero mismatches.
- err_cnt  output  3  mismatch count of the current/last run, 0..4.
- fail_vec  output  4  bit i set if vector i mismatched.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - gate_a=0, gate_b=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.
  - Internal vector index=0, settle counter=0.
  - Reset mid-run aborts immediately with the same values; no done pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - gate_a/gate_b=0, busy=0.
  - start=1 at an edge → RUN. At the same edge: idx=0, cnt=0, err_cnt=0, fail_vec=0, pass=0.
- RUN:
  - busy=1; {gate_a,gate_b}=idx (registered outputs, valid from the first RUN cycle).
  - cnt increments each cycle.
  - At the edge where cnt==SETTLE_CYC-1:
    - Compare gate_y against EXP_TT[idx] using case equality; X or Z on gate_y counts as a mismatch.
    - On mismatch: err_cnt+=1 and fail_vec[idx]=1.
    - cnt=0. If idx==3 → FIN, else idx+=1.
- FIN (exactly one cycle):
  - done=1, busy=0.
  - pass=1 iff err_cnt==0, counting the final vector's result.
  - gate_a/gate_b return to 0.
  - Next edge → IDLE unconditionally.
- Latency: with start accepted at edge E0, busy is high for 4*SETTLE_CYC cycles and done is high in the cycle after edge E0+4*SETTLE_CYC.
- Results hold: pass, err_cnt and fail_vec hold their values from FIN until the next accepted start.
- start handling:
  - start in RUN or FIN is ignored (no restart, no queueing).
  - start held high continuously re-triggers a new run on the IDLE cycle after FIN, i.e. back-to-back runs with one IDLE cycle between them.
- No combinational path from any input to any output; all outputs are registered.
- err_cnt saturates naturally at 4; no wrap is possible.

Test Plan:
1. Good AND gate, defaults:
   - Stimulus: pulse start.
   - Expect: {a,b} steps 00, 01, 10, 11, two cycles each.
   - Expect: busy high 8 cycles, then done for 1 cycle, pass=1, err_cnt=0, fail_vec=0000.
2. Stuck-at-1 output (gate_y tied 1), EXP_TT=4'b1000:
   - Expect: done, pass=0, err_cnt=3, fail_vec=0111.
3. Bad vector 10 only (gate_y forced 1 while a=1,b=0):
   - Expect: err_cnt=1, fail_vec=0100, pass=0.
   - Then a second run with a good gate: the start clears the results and the run ends with pass=1, fail_vec=0000.
4. Reset mid-run:
   - Stimulus: assert rst_n=0 during the vector-01 window, release, then pulse start.
   - Expect: all outputs 0 the cycle after reset, no done pulse.
   - Expect: the fresh run starts at vector 00 and ends normally.
5. start asserted during RUN, and start held high:
   - Expect: the mid-run start does not alter sequencing or timing.
   - Expect: with start held high, the second run's busy rises exactly 2 cycles after the first run's done.
6. SETTLE_CYC=1 with an OR gate (EXP_TT=4'b1110), plus gate_y=X on vector 11:
   - Expect: busy 4 cycles, then done.
   - Expect: fail_vec=1000, err_cnt=1, pass=0.
